// File: rtl/ebus_xfer.sv
// -----------------------------------------------------------------------------
// ebus_xfer
//
// EBOX-side EBUS I/O cycle sequencer (KL10). Accepts one CONO/CONI/DATAO/DATAI
// request, presents controller select and function on the EBUS, raises DEMAND
// after a setup interval, waits for the addressed device's TRANSFER, releases
// the bus and reports completion. Input functions (CONI/DATAI) capture the
// muxed EBUS data word into o_rdata on the edge TRANSFER is seen.
//
// Ports
//   i_clk          system clock, all state changes on posedge
//   i_resetN       synchronous active-low reset
//   i_req          start request, sampled only while idle
//   i_func         0=CONO 1=CONI 2=DATAO 3=DATAI, 4..7 illegal
//   i_dev          target device code
//   i_wdata        output data for CONO/DATAO
//   o_busy         high whenever the sequencer is not idle
//   o_done         one-cycle completion pulse
//   o_timedOut     valid with o_done: TRANSFER handshake failed
//   o_illegal      valid with o_done: function code was 4..7
//   o_rdata        captured input word, held until the next accepted request
//   o_ebusCS       controller select
//   o_ebusFunc     function code to devices
//   o_ebusDemand   EBUS DEMAND
//   o_ebusDrive    this block drives EBUS data (output functions only)
//   o_ebusDataOut  data driven while o_ebusDrive=1
//   i_ebusXfer     TRANSFER from the addressed device
//   i_ebusData     muxed EBUS data (0 when nothing drives it)
// -----------------------------------------------------------------------------
module ebus_xfer #(
  parameter int DATA_W    = 36,
  parameter int DEV_W     = 7,
  parameter int SETUP_CYC = 2,   // 1..15
  parameter int TIMEOUT   = 63   // 1..255
) (
  input  logic              i_clk,
  input  logic              i_resetN,
  input  logic              i_req,
  input  logic [2:0]        i_func,
  input  logic [DEV_W-1:0]  i_dev,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timedOut,
  output logic              o_illegal,
  output logic [DATA_W-1:0] o_rdata,
  output logic [DEV_W-1:0]  o_ebusCS,
  output logic [2:0]        o_ebusFunc,
  output logic              o_ebusDemand,
  output logic              o_ebusDrive,
  output logic [DATA_W-1:0] o_ebusDataOut,
  input  logic              i_ebusXfer,
  input  logic [DATA_W-1:0] i_ebusData
);

  // SETUP is left when the counter equals SETUP_CYC, so DEMAND rises
  // SETUP_CYC+1 clocks after the edge that accepted the request.
  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC);
  // The timeout counter starts at 0 on state entry; hitting TIMEOUT-1 on an
  // edge means TIMEOUT cycles have been spent waiting.
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_DEMAND  = 3'd2,
    S_RELEASE = 3'd3,
    S_FIN     = 3'd4
  } state_t;

  state_t              r_state;
  logic [3:0]          r_setup_cnt;
  logic [7:0]          r_tmo_cnt;
  logic                r_is_input;    // latched func is CONI/DATAI
  logic                r_timed_flag;  // handshake failure seen this cycle
  logic                r_illegal_flag;

  logic                r_busy;
  logic                r_done;
  logic                r_timed_out;
  logic                r_illegal;
  logic [DATA_W-1:0]   r_rdata;
  logic [DEV_W-1:0]    r_ebus_cs;
  logic [2:0]          r_ebus_func;
  logic                r_ebus_demand;
  logic                r_ebus_drive;
  logic [DATA_W-1:0]   r_ebus_data_out;

  // Legal functions have bit 2 clear; bit 0 set marks an input function.
  logic w_func_legal;
  logic w_func_input;

  assign w_func_legal = ~i_func[2];
  assign w_func_input = i_func[0];

  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      r_state         <= S_IDLE;
      r_setup_cnt     <= '0;
      r_tmo_cnt       <= '0;
      r_is_input      <= 1'b0;
      r_timed_flag    <= 1'b0;
      r_illegal_flag  <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_timed_out     <= 1'b0;
      r_illegal       <= 1'b0;
      r_rdata         <= '0;
      r_ebus_cs       <= '0;
      r_ebus_func     <= '0;
      r_ebus_demand   <= 1'b0;
      r_ebus_drive    <= 1'b0;
      r_ebus_data_out <= '0;
    end else begin
      // Completion status is only meaningful alongside the done pulse.
      r_done      <= 1'b0;
      r_timed_out <= 1'b0;
      r_illegal   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_busy         <= 1'b1;
            r_timed_flag   <= 1'b0;
            if (w_func_legal) begin
              // Select, function and output data are latched straight into
              // the bus output registers and held until the cycle finishes.
              r_is_input      <= w_func_input;
              r_ebus_cs       <= i_dev;
              r_ebus_func     <= i_func;
              r_ebus_drive    <= ~w_func_input;
              r_ebus_data_out <= w_func_input ? '0 : i_wdata;
              r_rdata         <= '0;
              r_setup_cnt     <= '0;
              r_tmo_cnt       <= '0;
              r_illegal_flag  <= 1'b0;
              r_state         <= S_SETUP;
            end else begin
              // Illegal code: report it without touching any EBUS signal.
              r_illegal_flag  <= 1'b1;
              r_state         <= S_FIN;
            end
          end
        end

        S_SETUP: begin
          // TRANSFER is deliberately not looked at here, so a stale TRANSFER
          // from a previous device cannot short-circuit the handshake.
          if (r_setup_cnt == SETUP_LAST) begin
            r_ebus_demand <= 1'b1;
            r_tmo_cnt     <= '0;
            r_state       <= S_DEMAND;
          end else if (r_setup_cnt != 4'hF) begin
            r_setup_cnt <= r_setup_cnt + 4'd1;
          end
        end

        S_DEMAND: begin
          if (i_ebusXfer) begin
            if (r_is_input) begin
              r_rdata <= i_ebusData;
            end
            r_ebus_demand <= 1'b0;
            r_tmo_cnt     <= '0;
            r_state       <= S_RELEASE;
          end else if (r_tmo_cnt == TMO_LAST) begin
            // No device answered; rdata stays at the cleared value.
            r_ebus_demand <= 1'b0;
            r_tmo_cnt     <= '0;
            r_timed_flag  <= 1'b1;
            r_state       <= S_RELEASE;
          end else if (r_tmo_cnt != 8'hFF) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end

        S_RELEASE: begin
          // Select, function and drive stay up until the device lets go.
          if (!i_ebusXfer) begin
            r_state <= S_FIN;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_timed_flag <= 1'b1;
            r_state      <= S_FIN;
          end else if (r_tmo_cnt != 8'hFF) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
        end

        S_FIN: begin
          // Done rises on the same edge the bus is released and we go idle,
          // so a request held high is taken on the following edge.
          r_done          <= 1'b1;
          r_timed_out     <= r_timed_flag;
          r_illegal       <= r_illegal_flag;
          r_ebus_cs       <= '0;
          r_ebus_func     <= '0;
          r_ebus_drive    <= 1'b0;
          r_ebus_data_out <= '0;
          r_ebus_demand   <= 1'b0;
          r_busy          <= 1'b0;
          r_timed_flag    <= 1'b0;
          r_illegal_flag  <= 1'b0;
          r_state         <= S_IDLE;
        end

        default: begin
          r_ebus_cs       <= '0;
          r_ebus_func     <= '0;
          r_ebus_drive    <= 1'b0;
          r_ebus_data_out <= '0;
          r_ebus_demand   <= 1'b0;
          r_busy          <= 1'b0;
          r_state         <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_timedOut    = r_timed_out;
  assign o_illegal     = r_illegal;
  assign o_rdata       = r_rdata;
  assign o_ebusCS      = r_ebus_cs;
  assign o_ebusFunc    = r_ebus_func;
  assign o_ebusDemand  = r_ebus_demand;
  assign o_ebusDrive   = r_ebus_drive;
  assign o_ebusDataOut = r_ebus_data_out;

endmodule

// File: tb/tb_ebus_xfer.sv
// -----------------------------------------------------------------------------
// tb_ebus_xfer
//
// Directed bench for ebus_xfer with default parameters (SETUP_CYC=2,
// TIMEOUT=63). A single initial block walks through CONI, DATAO, no-response,
// stuck-TRANSFER, illegal/overlap/back-to-back and reset-mid-DEMAND cases.
// -----------------------------------------------------------------------------
module tb_ebus_xfer;

  localparam int DATA_W = 36;
  localparam int DEV_W  = 7;

  logic              i_clk;
  logic              i_resetN;
  logic              i_req;
  logic [2:0]        i_func;
  logic [DEV_W-1:0]  i_dev;
  logic [DATA_W-1:0] i_wdata;
  logic              o_busy;
  logic              o_done;
  logic              o_timedOut;
  logic              o_illegal;
  logic [DATA_W-1:0] o_rdata;
  logic [DEV_W-1:0]  o_ebusCS;
  logic [2:0]        o_ebusFunc;
  logic              o_ebusDemand;
  logic              o_ebusDrive;
  logic [DATA_W-1:0] o_ebusDataOut;
  logic              i_ebusXfer;
  logic [DATA_W-1:0] i_ebusData;

  int n_cmp = 0;
  int n_err = 0;
  logic drive_seen;
  logic done_seen;
  int   cyc;

  ebus_xfer #(
    .DATA_W(DATA_W), .DEV_W(DEV_W), .SETUP_CYC(2), .TIMEOUT(63)
  ) dut (
    .i_clk(i_clk), .i_resetN(i_resetN), .i_req(i_req), .i_func(i_func),
    .i_dev(i_dev), .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done),
    .o_timedOut(o_timedOut), .o_illegal(o_illegal), .o_rdata(o_rdata),
    .o_ebusCS(o_ebusCS), .o_ebusFunc(o_ebusFunc), .o_ebusDemand(o_ebusDemand),
    .o_ebusDrive(o_ebusDrive), .o_ebusDataOut(o_ebusDataOut),
    .i_ebusXfer(i_ebusXfer), .i_ebusData(i_ebusData)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // One clock; outputs are sampled and inputs changed 1 time unit after
  // the rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
    drive_seen = drive_seen | o_ebusDrive;
    done_seen  = done_seen  | o_done;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  // Tick until done rises or the bound expires; returns ticks taken.
  task automatic wait_done(input int max, output int n);
    n = 0;
    while (o_done !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_demand(input int max, output int n);
    n = 0;
    while (o_ebusDemand !== 1'b1 && n < max) begin
      tick();
      n++;
    end
  endtask

  initial begin
    i_resetN   = 1'b0;
    i_req      = 1'b0;
    i_func     = 3'd0;
    i_dev      = '0;
    i_wdata    = '0;
    i_ebusXfer = 1'b0;
    i_ebusData = '0;
    drive_seen = 1'b0;
    done_seen  = 1'b0;

    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_busy",   o_busy,        1'b0);
    chk("rst_done",   o_done,        1'b0);
    chk("rst_rdata",  o_rdata,       36'o0);
    chk("rst_cs",     o_ebusCS,      7'o0);
    chk("rst_demand", o_ebusDemand,  1'b0);
    chk("rst_drive",  o_ebusDrive,   1'b0);
    chk("rst_dout",   o_ebusDataOut, 36'o0);
    i_resetN = 1'b1;
    tick();
    $display("reset checked");

    // ---------------- CONI, exact timing ----------------
    drive_seen = 1'b0;
    i_req = 1'b1; i_func = 3'd1; i_dev = 7'o004; i_wdata = 36'o555555555555;
    tick();                                   // e0: accepted
    i_req = 1'b0;
    chk("coni_busy",   o_busy,       1'b1);
    chk("coni_cs",     o_ebusCS,     7'o004);
    chk("coni_func",   o_ebusFunc,   3'd1);
    chk("coni_dem_e0", o_ebusDemand, 1'b0);
    tick();                                   // e1
    tick();                                   // e2
    chk("coni_dem_e2", o_ebusDemand, 1'b0);
    tick();                                   // e3
    chk("coni_dem_e3", o_ebusDemand, 1'b1);
    tick(); tick();                           // e4, e5
    chk("coni_dem_e5", o_ebusDemand, 1'b1);
    i_ebusXfer = 1'b1; i_ebusData = 36'o123456701234;
    tick();                                   // e6: capture
    chk("coni_dem_fall", o_ebusDemand, 1'b0);
    chk("coni_rdata_cap", o_rdata, 36'o123456701234);
    tick(); tick();                           // e7, e8
    i_ebusXfer = 1'b0; i_ebusData = '0;
    tick();                                   // e9: -> FIN
    chk("coni_nodone_e9", o_done, 1'b0);
    chk("coni_cs_held", o_ebusCS, 7'o004);
    tick();                                   // e10: done
    chk("coni_done",   o_done,     1'b1);
    chk("coni_tmo",    o_timedOut, 1'b0);
    chk("coni_ill",    o_illegal,  1'b0);
    chk("coni_cs_clr", o_ebusCS,   7'o0);
    chk("coni_busy0",  o_busy,     1'b0);
    chk("coni_rdata",  o_rdata,    36'o123456701234);
    chk("coni_nodrive", drive_seen, 1'b0);
    tick();
    chk("coni_done_1cyc", o_done, 1'b0);
    chk("coni_rdata_hold", o_rdata, 36'o123456701234);
    $display("CONI dev=004 rdata=%0o", o_rdata);

    // ---------------- DATAO ----------------
    i_req = 1'b1; i_func = 3'd2; i_dev = 7'o010; i_wdata = 36'o777000111222;
    tick();
    i_req = 1'b0;
    chk("dato_drive_setup", o_ebusDrive,   1'b1);
    chk("dato_dout_setup",  o_ebusDataOut, 36'o777000111222);
    chk("dato_rdata_clr",   o_rdata,       36'o0);
    tick(); tick(); tick();
    chk("dato_demand", o_ebusDemand, 1'b1);
    chk("dato_drive_dem", o_ebusDrive, 1'b1);
    i_ebusXfer = 1'b1;
    tick();                                   // -> RELEASE
    chk("dato_drive_rel", o_ebusDrive,   1'b1);
    chk("dato_dout_rel",  o_ebusDataOut, 36'o777000111222);
    i_ebusXfer = 1'b0;
    wait_done(5, cyc);
    chk("dato_done",    o_done,        1'b1);
    chk("dato_drive0",  o_ebusDrive,   1'b0);
    chk("dato_dout0",   o_ebusDataOut, 36'o0);
    chk("dato_rdata0",  o_rdata,       36'o0);
    chk("dato_tmo",     o_timedOut,    1'b0);
    $display("DATAO dev=010 wdata=%0o done after %0d", i_wdata, cyc);
    tick();

    // ---------------- no response (DATAI) ----------------
    i_req = 1'b1; i_func = 3'd3; i_dev = 7'o020; i_wdata = '0;
    tick();
    i_req = 1'b0;
    wait_demand(10, cyc);
    chk("nr_demand_lat", cyc, 3);
    cyc = 1;
    while (cyc < 200) begin
      tick();
      if (o_ebusDemand !== 1'b1) break;
      cyc++;
    end
    chk("nr_demand_len", cyc, 63);
    wait_done(10, cyc);
    chk("nr_done",  o_done,     1'b1);
    chk("nr_tmo",   o_timedOut, 1'b1);
    chk("nr_ill",   o_illegal,  1'b0);
    chk("nr_rdata", o_rdata,    36'o0);
    $display("DATAI dev=020 no response: timedOut=%0b", o_timedOut);
    tick();

    // ---------------- stuck TRANSFER, stale at SETUP entry (CONI) -------
    i_ebusXfer = 1'b1; i_ebusData = 36'o000000001234;
    i_req = 1'b1; i_func = 3'd1; i_dev = 7'o030;
    tick();                                   // e0
    i_req = 1'b0;
    tick(); tick();                           // e1, e2
    chk("stk_setup_rdata", o_rdata, 36'o0);
    chk("stk_setup_dem",   o_ebusDemand, 1'b0);
    tick();                                   // e3: DEMAND
    chk("stk_demand", o_ebusDemand, 1'b1);
    tick();                                   // e4: capture, RELEASE
    chk("stk_rdata_cap", o_rdata, 36'o000000001234);
    wait_done(100, cyc);
    chk("stk_rel_len", cyc, 64);
    chk("stk_done",  o_done,     1'b1);
    chk("stk_tmo",   o_timedOut, 1'b1);
    chk("stk_rdata", o_rdata,    36'o000000001234);
    $display("CONI dev=030 stuck xfer: timedOut=%0b rdata=%0o", o_timedOut, o_rdata);
    i_ebusXfer = 1'b0; i_ebusData = '0;
    tick();

    // ---------------- illegal function ----------------
    i_req = 1'b1; i_func = 3'd5; i_dev = 7'o040; i_wdata = 36'o111111111111;
    tick();
    i_req = 1'b0;
    chk("ill_busy",  o_busy,       1'b1);
    chk("ill_cs",    o_ebusCS,     7'o0);
    chk("ill_dem",   o_ebusDemand, 1'b0);
    chk("ill_drive", o_ebusDrive,  1'b0);
    tick();
    chk("ill_done",  o_done,     1'b1);
    chk("ill_flag",  o_illegal,  1'b1);
    chk("ill_tmo",   o_timedOut, 1'b0);
    chk("ill_dout",  o_ebusDataOut, 36'o0);
    $display("func=5 illegal=%0b", o_illegal);
    tick();

    // ---------------- overlap and back-to-back ----------------
    i_req = 1'b1; i_func = 3'd0; i_dev = 7'o050; i_wdata = 36'o000000000077;
    tick();                                   // e0 accepted
    i_req = 1'b0;
    tick();                                   // e1
    i_req = 1'b1; i_func = 3'd2; i_dev = 7'o077;
    tick();                                   // e2: ignored
    i_req = 1'b0;
    chk("ovl_cs",   o_ebusCS,   7'o050);
    chk("ovl_func", o_ebusFunc, 3'd0);
    tick();                                   // e3 DEMAND
    i_ebusXfer = 1'b1;
    tick();                                   // e4 RELEASE
    i_ebusXfer = 1'b0;
    i_req = 1'b1; i_func = 3'd3; i_dev = 7'o060;
    tick();                                   // e5 FIN
    tick();                                   // e6 done
    chk("b2b_done",  o_done, 1'b1);
    chk("b2b_busy0", o_busy, 1'b0);
    tick();                                   // e7 new request taken
    i_req = 1'b0;
    chk("b2b_busy1", o_busy,     1'b1);
    chk("b2b_cs",    o_ebusCS,   7'o060);
    chk("b2b_func",  o_ebusFunc, 3'd3);
    wait_demand(10, cyc);
    chk("b2b_demand", o_ebusDemand, 1'b1);
    i_ebusXfer = 1'b1; i_ebusData = 36'o000000000055;
    tick();
    i_ebusXfer = 1'b0; i_ebusData = '0;
    wait_done(10, cyc);
    chk("b2b_rdata", o_rdata, 36'o000000000055);
    $display("back-to-back DATAI dev=060 rdata=%0o", o_rdata);
    tick();

    // ---------------- reset mid-DEMAND ----------------
    i_req = 1'b1; i_func = 3'd3; i_dev = 7'o070;
    tick();
    i_req = 1'b0;
    wait_demand(10, cyc);
    chk("rsm_demand", o_ebusDemand, 1'b1);
    i_resetN = 1'b0;
    done_seen = 1'b0;
    tick();
    chk("rsm_dem0",  o_ebusDemand, 1'b0);
    chk("rsm_busy0", o_busy,       1'b0);
    chk("rsm_cs0",   o_ebusCS,     7'o0);
    chk("rsm_func0", o_ebusFunc,   3'd0);
    i_resetN = 1'b1;
    i_ebusXfer = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    i_ebusXfer = 1'b0;
    chk("rsm_nodone", done_seen, 1'b0);
    chk("rsm_idle",   o_busy,    1'b0);
    $display("reset mid-DEMAND dev=070 busy=%0b", o_busy);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
